// File: rtl/lsu_ctrl.sv
// lsu_ctrl: execute/memory-stage load/store unit.
// Computes the effective address, checks alignment and runs one req/ack access per op.
module lsu_ctrl #(
    parameter int XLEN     = 32,
    parameter int AW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_store,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [XLEN-1:0]   i_base,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [4:0]        i_rd,
    output logic              o_busy,
    output logic              o_rd_we,
    output logic [4:0]        o_rd,
    output logic [XLEN-1:0]   o_rd_val,
    output logic              o_done,
    output logic              o_misalign,
    output logic              o_timeout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
    state_t state, state_nx;

    logic [XLEN-1:0] ea;
    logic [OW-1:0]   off;
    logic [3:0]      size_mask;
    logic [8:0]      be_mask;
    logic            aligned;
    logic            accept;
    logic            reject;
    logic            expire;

    logic            store_q;
    logic            uns_q;
    logic [1:0]      size_q;
    logic [OW-1:0]   off_q;
    logic [4:0]      rd_q;
    logic [7:0]      wait_cnt;

    logic [XLEN-1:0]        shifted;
    logic [XLEN-1:0]        left;
    logic [XLEN-1:0]        ext;
    logic signed [XLEN-1:0] sext;
    logic [6:0]             pad;

    assign ea        = i_base + i_imm;
    assign off       = ea[OW-1:0];
    assign size_mask = (4'd1 << i_size) - 4'd1;
    assign be_mask   = (9'd1 << (4'd1 << i_size)) - 9'd1;
    // A doubleword on a 32-bit core is illegal and is rejected like a misalignment.
    assign aligned   = ((off & size_mask[OW-1:0]) == '0)
                       && !(i_size == 2'd3 && XLEN != 64);
    assign accept    = (state == IDLE) && i_valid && aligned;
    assign reject    = (state == IDLE) && i_valid && !aligned;
    assign expire    = !mem_ack && (wait_cnt == 8'(MAX_WAIT - 1));
    assign o_busy    = (state != IDLE) || (i_valid && aligned);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        o_done   = 1'b0;
        o_rd_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                mem_we  = store_q;
                if (mem_ack) begin
                    state_nx = store_q ? IDLE : WB;
                    o_done   = store_q;
                end else if (expire) begin
                    state_nx = IDLE;
                end
            end
            WB: begin
                o_rd_we  = (o_rd != 5'd0);
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Right-justify the addressed lanes, then extend by a shift pair.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        unique case (size_q)
            2'd0:    pad = 7'(XLEN - 8);
            2'd1:    pad = 7'(XLEN - 16);
            2'd2:    pad = 7'(XLEN - 32);
            default: pad = 7'd0;
        endcase
        left = shifted << pad;
        sext = $signed(left) >>> pad;
        ext  = uns_q ? (left >> pad) : sext;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            store_q    <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'd0;
            off_q      <= '0;
            rd_q       <= 5'd0;
            wait_cnt   <= 8'd0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            o_rd       <= 5'd0;
            o_rd_val   <= '0;
            o_misalign <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            o_misalign <= reject;
            o_timeout  <= (state == REQ) && expire;
            if (accept) begin
                store_q   <= i_store;
                uns_q     <= i_unsigned;
                size_q    <= i_size;
                off_q     <= off;
                rd_q      <= i_rd;
                wait_cnt  <= 8'd0;
                mem_addr  <= AW'(ea) & ~AW'(NB - 1);
                mem_be    <= be_mask[NB-1:0] << off;
                mem_wdata <= i_wdata << {off, 3'b000};
            end else if (state == REQ && !mem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == REQ && mem_ack && !store_q) begin
                o_rd     <= rd_q;
                o_rd_val <= ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl at XLEN=32 and XLEN=64
// against a byte-lane reference model.
module tb_lsu_ctrl;
    localparam int MW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel64;
    logic        vld;
    logic        st;
    logic        uns;
    logic        ack;
    logic [1:0]  size;
    logic [63:0] base;
    logic [63:0] imm;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [4:0]  rd;

    logic v32, v64, a32, a64;
    assign v32 = vld & ~sel64;
    assign v64 = vld & sel64;
    assign a32 = ack & ~sel64;
    assign a64 = ack & sel64;

    logic        busy32, rdwe32, done32, mis32, to32, req32, we32;
    logic [4:0]  rd32;
    logic [31:0] val32, addr32, wd32;
    logic [3:0]  be32;

    logic        busy64, rdwe64, done64, mis64, to64, req64, we64;
    logic [4:0]  rd64;
    logic [63:0] val64, wd64;
    logic [31:0] addr64;
    logic [7:0]  be64;

    lsu_ctrl #(.XLEN(32), .AW(32), .MAX_WAIT(MW)) u32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v32), .i_store(st),
        .i_size(size), .i_unsigned(uns), .i_base(base[31:0]),
        .i_imm(imm[31:0]), .i_wdata(wdata[31:0]), .i_rd(rd),
        .o_busy(busy32), .o_rd_we(rdwe32), .o_rd(rd32), .o_rd_val(val32),
        .o_done(done32), .o_misalign(mis32), .o_timeout(to32),
        .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_be(be32),
        .mem_wdata(wd32), .mem_ack(a32), .mem_rdata(rdata[31:0])
    );

    lsu_ctrl #(.XLEN(64), .AW(32), .MAX_WAIT(MW)) u64 (
        .i_clk(clk), .i_rst(rst), .i_valid(v64), .i_store(st),
        .i_size(size), .i_unsigned(uns), .i_base(base),
        .i_imm(imm), .i_wdata(wdata), .i_rd(rd),
        .o_busy(busy64), .o_rd_we(rdwe64), .o_rd(rd64), .o_rd_val(val64),
        .o_done(done64), .o_misalign(mis64), .o_timeout(to64),
        .mem_req(req64), .mem_we(we64), .mem_addr(addr64), .mem_be(be64),
        .mem_wdata(wd64), .mem_ack(a64), .mem_rdata(rdata)
    );

    logic        s_busy, s_rdwe, s_done, s_mis, s_to, s_req, s_we;
    logic [4:0]  s_rd;
    logic [63:0] s_val, s_wd;
    logic [31:0] s_addr;
    logic [7:0]  s_be;

    assign s_busy = sel64 ? busy64 : busy32;
    assign s_rdwe = sel64 ? rdwe64 : rdwe32;
    assign s_done = sel64 ? done64 : done32;
    assign s_mis  = sel64 ? mis64 : mis32;
    assign s_to   = sel64 ? to64 : to32;
    assign s_req  = sel64 ? req64 : req32;
    assign s_we   = sel64 ? we64 : we32;
    assign s_rd   = sel64 ? rd64 : rd32;
    assign s_val  = sel64 ? val64 : {32'd0, val32};
    assign s_wd   = sel64 ? wd64 : {32'd0, wd32};
    assign s_addr = sel64 ? addr64 : addr32;
    assign s_be   = sel64 ? be64 : {4'd0, be32};

    int          ncmp;
    int          nfail;
    bit          pend_mis;
    bit          pend_to;
    logic [4:0]  last_rd;
    logic [63:0] last_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Load result from the byte lanes, extended arithmetically.
    function automatic logic [63:0] ref_load(input bit x64, input logic [63:0] data,
                                             input int off, input int sz, input bit un);
        logic [63:0] v = 64'd0;
        logic [63:0] ones = 64'hFFFF_FFFF_FFFF_FFFF;
        int n = 1 << sz;
        for (int b = 0; b < n; b++) v[8*b +: 8] = data[8*(off+b) +: 8];
        if (!un && n < 8 && v[8*n-1]) v = v | (ones << (8*n));
        if (!x64) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic garble();
        vld   = 1'($urandom_range(0, 1));
        st    = 1'($urandom_range(0, 1));
        uns   = 1'($urandom_range(0, 1));
        size  = 2'($urandom_range(0, 3));
        base  = {$urandom, $urandom};
        imm   = {$urandom, $urandom};
        wdata = {$urandom, $urandom};
        rd    = 5'($urandom_range(0, 31));
        rdata = {$urandom, $urandom};
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        vld = 1'b0;
        ack = 1'b0;
        #1;
        chk("idle_mis", s_mis, pend_mis);
        chk("idle_to", s_to, pend_to);
        chk("idle_busy", s_busy, 0);
        chk("idle_req", s_req, 0);
        pend_mis = 0;
        pend_to  = 0;
    endtask

    task automatic do_op(input bit x64, input bit s, input int sz, input bit u,
                         input logic [63:0] b, input logic [63:0] im,
                         input logic [63:0] wd, input logic [4:0] r,
                         input int lat, input logic [63:0] rdat);
        int          nb = x64 ? 8 : 4;
        int          off;
        int          n;
        bit          ok;
        logic [63:0] xmask;
        logic [63:0] ea;
        logic [63:0] exp_addr;
        logic [63:0] exp_wd;
        logic [63:0] exp_val;
        logic [7:0]  be;
        xmask    = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        ea       = (b + im) & xmask;
        off      = int'(ea % nb);
        n        = 1 << sz;
        ok       = (ea % n == 0) && !(sz == 3 && !x64);
        exp_addr = (ea - 64'(off)) & 64'hFFFF_FFFF;
        exp_wd   = (wd << (8*off)) & xmask;
        exp_val  = ref_load(x64, rdat & xmask, off, sz, u);
        be       = 8'd0;
        for (int k = 0; k < nb; k++) be[k] = (k >= off && k < off + n);

        @(negedge clk);
        vld   = 1'b1;
        st    = s;
        size  = 2'(sz);
        uns   = u;
        base  = b;
        imm   = im;
        wdata = wd;
        rd    = r;
        ack   = 1'b0;
        rdata = {$urandom, $urandom};
        #1;
        chk("pulse_mis", s_mis, pend_mis);
        chk("pulse_to", s_to, pend_to);
        chk("idle_done", s_done, 0);
        chk("idle_rdwe", s_rdwe, 0);
        chk("idle_req", s_req, 0);
        chk("busy_accept", s_busy, ok);
        chk("rd_hold", s_rd, last_rd);
        chk("val_hold", s_val, last_val);
        pend_mis = !ok;
        pend_to  = 0;
        if (!ok) return;

        for (int c = 1; c <= MW; c++) begin
            @(negedge clk);
            garble();
            ack = (c == lat);
            if (c == lat) rdata = rdat;
            #1;
            chk("req", s_req, 1);
            chk("we", s_we, s);
            chk("addr", s_addr, exp_addr);
            chk("be", s_be, be);
            if (s) chk("wdata", s_wd, exp_wd);
            chk("busy_req", s_busy, 1);
            chk("done_req", s_done, s && c == lat);
            chk("rdwe_req", s_rdwe, 0);
            chk("to_req", s_to, 0);
            chk("val_hold_req", s_val, last_val);
            if (c == lat) break;
        end
        if (lat > MW) begin
            pend_to = 1;
            return;
        end
        if (s) return;

        @(negedge clk);
        garble();
        ack = 1'b0;
        #1;
        chk("wb_rdwe", s_rdwe, r != 5'd0);
        chk("wb_done", s_done, 1);
        chk("wb_rd", s_rd, r);
        chk("wb_val", s_val, exp_val);
        chk("wb_req", s_req, 0);
        chk("wb_busy", s_busy, 1);
        last_rd  = r;
        last_val = exp_val;
    endtask

    task automatic rand_op(input bit x64);
        int          s_imm = int'($urandom_range(0, 64)) - 32;
        int          sz = int'($urandom_range(0, 3));
        logic [63:0] b = {$urandom, $urandom};
        do_op(x64, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              b, 64'(longint'(s_imm)), {$urandom, $urandom},
              5'($urandom_range(0, 31)), int'($urandom_range(1, MW + 1)),
              {$urandom, $urandom});
    endtask

    initial begin
        ncmp     = 0;
        nfail    = 0;
        pend_mis = 0;
        pend_to  = 0;
        last_rd  = 5'd0;
        last_val = 64'd0;
        rst      = 1'b0;
        sel64    = 1'b0;
        vld      = 1'b0;
        st       = 1'b0;
        uns      = 1'b0;
        ack      = 1'b0;
        size     = 2'd0;
        base     = 64'd0;
        imm      = 64'd0;
        wdata    = 64'd0;
        rdata    = 64'd0;
        rd       = 5'd0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", s_busy, 0);
        chk("rst_req", s_req, 0);
        chk("rst_rdwe", s_rdwe, 0);
        chk("rst_done", s_done, 0);
        chk("rst_val", s_val, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_be", s_be, 0);
        @(negedge clk);
        rst = 1'b1;

        do_op(0, 0, 0, 0, 64'h100, 64'd3, 64'd0, 5'd5, 1, 64'h80FF_0000);
        chk("lb_val", s_val, 64'hFFFF_FF80);
        do_op(0, 0, 1, 1, 64'h100, 64'd2, 64'd0, 5'd6, 1, 64'h8001_1234);
        chk("lhu_val", s_val, 64'h0000_8001);
        do_op(0, 1, 0, 0, 64'h200, 64'd1, 64'hAB, 5'd7, 4, 64'd0);
        do_op(0, 0, 2, 0, 64'h100, 64'd2, 64'd0, 5'd8, 1, 64'd0);
        do_op(0, 0, 3, 0, 64'h100, 64'd0, 64'd0, 5'd8, 1, 64'd0);
        do_op(0, 0, 2, 0, 64'h300, 64'd0, 64'd0, 5'd9, MW + 1, 64'd0);
        do_op(0, 0, 2, 0, 64'h400, 64'd4, 64'd0, 5'd0, 2, 64'h1234_5678);
        do_op(0, 1, 2, 0, 64'h500, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF, 5'd1, 1, 64'd0);

        // Reset asserted while a load is waiting for its ack.
        @(negedge clk);
        vld  = 1'b1;
        st   = 1'b0;
        size = 2'd2;
        uns  = 1'b0;
        base = 64'h600;
        imm  = 64'd0;
        rd   = 5'd3;
        ack  = 1'b0;
        #1;
        chk("pre_rst_busy", s_busy, 1);
        @(negedge clk);
        vld = 1'b0;
        #1;
        chk("pre_rst_req", s_req, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", s_req, 0);
        chk("arst_busy", s_busy, 0);
        chk("arst_rd", s_rd, 0);
        chk("arst_val", s_val, 0);
        chk("arst_addr", s_addr, 0);
        chk("arst_be", s_be, 0);
        chk("arst_wd", s_wd, 0);
        chk("arst_we", s_we, 0);
        @(negedge clk);
        rst      = 1'b1;
        last_rd  = 5'd0;
        last_val = 64'd0;
        pend_mis = 0;
        pend_to  = 0;
        idle_cycle();

        for (int i = 0; i < 200; i++) rand_op(0);
        idle_cycle();

        sel64    = 1'b1;
        last_rd  = 5'd0;
        last_val = 64'd0;
        do_op(1, 0, 2, 0, 64'h100, 64'd4, 64'd0, 5'd3, 1, 64'h8000_0000_1234_5678);
        chk("lw64_val", s_val, 64'hFFFF_FFFF_8000_0000);
        do_op(1, 0, 2, 1, 64'h100, 64'd4, 64'd0, 5'd4, 2, 64'h8000_0000_1234_5678);
        chk("lwu64_val", s_val, 64'h0000_0000_8000_0000);
        do_op(1, 0, 3, 0, 64'h108, 64'd0, 64'd0, 5'd5, 3, 64'hFEDC_BA98_7654_3210);
        do_op(1, 1, 3, 0, 64'h110, 64'd0, 64'h0123_4567_89AB_CDEF, 5'd6, 1, 64'd0);
        do_op(1, 0, 3, 0, 64'h104, 64'd0, 64'd0, 5'd7, 1, 64'd0);
        for (int i = 0; i < 150; i++) rand_op(1);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
